// File: rtl/mix_pipe_datapath.sv
// Three-stage pipelined word mixer: IN_W-bit word -> OUT_W-bit digest, with an
// optional running XOR accumulator (mode 1) and synchronous clear.
module mix_pipe_datapath #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3,
  parameter int ACC_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int STAGES = 3;
  localparam int NCHUNK = (ACC_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W  = NCHUNK * OUT_W;

  typedef struct packed {
    logic [ACC_W-1:0] t0;
    logic [3:0]       t1;
    logic             mode;
  } stage_a_t;

  typedef struct packed {
    logic [ACC_W-1:0] p;
    logic             mode;
  } stage_b_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  stage_a_t        sa, sa_d;
  stage_b_t        sb;
  logic [ACC_W-1:0] x;
  logic [PAD_W-1:0] p_pad;
  logic [OUT_W-1:0] r, acc, acc_base, mixed;

  // One enable for the whole pipe: bubbles are carried, never squeezed out.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    x       = ACC_W'(in_data);
    sa_d.t0 = x + (x << 1) + ACC_W'(1);
    sa_d.t1 = x[3:0] ^ sa_d.t0[3:0];
    sa_d.mode = in_mode;
  end

  // Fold the product into OUT_W-bit chunks, top chunk zero-padded.
  always_comb begin
    p_pad = '0;
    p_pad[ACC_W-1:0] = sb.p;
    r = '0;
    for (int i = 0; i < NCHUNK; i++) r ^= p_pad[i*OUT_W +: OUT_W];
  end

  // A clear on the same edge as a mode-1 load wins first, so the item seeds acc.
  assign acc_base = acc_clr ? '0 : acc;
  assign mixed    = acc_base ^ r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
    end else if (en) begin
      if (in_valid) sa <= sa_d;
      if (vld_pipe[1]) begin
        sb.p    <= sa.t0 * ACC_W'(sa.t1);
        sb.mode <= sa.mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      acc      <= '0;
    end else begin
      if (en && vld_pipe[2]) out_data <= sb.mode ? mixed : r;
      if (en && vld_pipe[2] && sb.mode) acc <= mixed;
      else if (acc_clr)                 acc <= '0;
    end
  end

endmodule

// File: tb/tb_mix_pipe_datapath.sv
// Directed table + scoreboarded sequences on the default build, plus a
// randomised run on a 16/5/32 build against an independent 64-bit model.
module tb_mix_pipe_datapath;

  logic       clk = 0;
  logic       rst;
  logic       in_valid, in_ready, in_mode, acc_clr, out_valid, out_ready;
  logic [7:0] in_data;
  logic [2:0] out_data;

  logic        r_in_valid, r_in_ready, r_in_mode, r_acc_clr, r_out_valid, r_out_ready;
  logic [15:0] r_in_data;
  logic [4:0]  r_out_data;

  always #5 clk = ~clk;

  mix_pipe_datapath dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  mix_pipe_datapath #(.IN_W(16), .OUT_W(5), .ACC_W(32)) rdut (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_data(r_in_data), .in_mode(r_in_mode), .acc_clr(r_acc_clr),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data));

  int n_checks = 0, n_fail = 0, n_out = 0;
  logic [31:0] sb[$];
  logic [31:0] macc;

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       clr;
    logic [2:0] e;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dig(input logic [31:0] x, input int aw, input int ow);
    logic [63:0] m, t0, t1, p;
    logic [31:0] r;
    m  = (64'd1 << aw) - 64'd1;
    t0 = (64'd3 * {32'd0, x} + 64'd1) & m;
    t1 = ({32'd0, x} & 64'd15) ^ (t0 & 64'd15);
    p  = (t0 * t1) & m;
    r  = 0;
    for (int i = 0; i < aw; i += ow) r ^= 32'((p >> i) & ((64'd1 << ow) - 64'd1));
    return r;
  endfunction

  task automatic do_reset();
    in_valid = 0; acc_clr = 0; out_ready = 1; in_data = 0; in_mode = 0;
    rst = 1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_out_valid_rel", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    sb.delete();
    macc = 0;
  endtask

  // Back-to-back stream with out_ready high; acc_clr aligned with the row's stage-C load.
  task automatic run_seg(input int start, input int n);
    for (int i = 0; i < n + 2; i++) begin
      in_valid  = (i < n);
      in_data   = (i < n) ? tbl[start+i].d : 8'd0;
      in_mode   = (i < n) ? tbl[start+i].m : 1'b0;
      acc_clr   = (i >= 2) ? tbl[start+i-2].clr : 1'b0;
      out_ready = 1;
      @(posedge clk);
      #1;
      if (i < 2) chk("latency_idle", 32'(out_valid), 0);
      else begin
        chk("tbl_valid", 32'(out_valid), 1);
        chk($sformatf("tbl_data[%0d]", start+i-2), 32'(out_data), 32'(tbl[start+i-2].e));
      end
    end
    in_valid = 0; acc_clr = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic m, input logic rdy, input logic clr);
    logic [31:0] e, r;
    in_valid = v; in_data = d; in_mode = m; out_ready = rdy; acc_clr = clr;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), e);
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      r = dig({24'd0, d}, 26, 3);
      if (m) begin macc ^= r; sb.push_back(macc); end
      else sb.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] held;
    int words, got, bound;
    logic [31:0] racc, re, rprev;
    logic rstall;
    logic [31:0] rq[$];

    r_in_valid = 0; r_in_data = 0; r_in_mode = 0; r_acc_clr = 0; r_out_ready = 1;

    tbl[0]  = '{8'd5,   1'b0, 1'b0, 3'd3};
    tbl[1]  = '{8'd0,   1'b0, 1'b0, 3'd1};
    tbl[2]  = '{8'd255, 1'b0, 1'b0, 3'd3};
    tbl[3]  = '{8'd5,   1'b1, 1'b0, 3'd3};
    tbl[4]  = '{8'd0,   1'b1, 1'b0, 3'd2};
    tbl[5]  = '{8'd255, 1'b1, 1'b1, 3'd3};
    tbl[6]  = '{8'd5,   1'b0, 1'b0, 3'd3};
    tbl[7]  = '{8'd0,   1'b1, 1'b0, 3'd2};
    tbl[8]  = '{8'd255, 1'b0, 1'b0, 3'd3};
    tbl[9]  = '{8'd5,   1'b1, 1'b0, 3'd1};
    tbl[10] = '{8'd200, 1'b1, 1'b0, 3'd3};
    tbl[11] = '{8'd1,   1'b1, 1'b0, 3'd5};
    tbl[12] = '{8'd3,   1'b0, 1'b0, 3'd0};
    tbl[13] = '{8'd1,   1'b1, 1'b1, 3'd6};
    tbl[14] = '{8'd200, 1'b0, 1'b0, 3'd2};
    tbl[15] = '{8'd5,   1'b0, 1'b0, 3'd3};
    tbl[16] = '{8'd0,   1'b1, 1'b0, 3'd1};
    tbl[17] = '{8'd255, 1'b0, 1'b0, 3'd3};
    tbl[18] = '{8'd5,   1'b1, 1'b0, 3'd2};

    do_reset();
    run_seg(0, 15);
    do_reset();
    run_seg(15, 4);

    // Backpressure: 4 stalled cycles with a word waiting at the input.
    do_reset();
    n_out = 0;
    step(1, 8'd5, 0, 1, 0);
    step(1, 8'd0, 1, 1, 0);
    step(1, 8'd255, 0, 1, 0);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'd3, 1, 0, 0);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(held));
    end
    step(1, 8'd3, 1, 1, 0);
    step(1, 8'd1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'd0, 0, 1, 0);
    chk("bp_count", 32'(n_out), 5);
    chk("bp_drained", 32'(sb.size()), 0);

    // Clear while stalled still takes effect.
    do_reset();
    step(1, 8'd5, 1, 0, 0);
    step(0, 8'd0, 0, 0, 0);
    step(0, 8'd0, 0, 0, 0);
    step(0, 8'd0, 0, 0, 1);
    macc = 0;
    chk("clr_stall_valid", 32'(out_valid), 1);
    chk("clr_stall_data", 32'(out_data), 3);
    step(1, 8'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'd0, 0, 1, 0);
    chk("clr_stall_drained", 32'(sb.size()), 0);

    // Reset with three accumulate items in flight.
    do_reset();
    step(1, 8'd5, 1, 1, 0);
    step(1, 8'd0, 1, 1, 0);
    step(1, 8'd255, 1, 1, 0);
    in_valid = 0;
    rst = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    macc = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 8'd0, 0, 1, 0);
      chk("post_rst_idle", 32'(out_valid), 0);
    end
    n_out = 0;
    step(1, 8'd5, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'd0, 0, 1, 0);
    chk("post_rst_count", 32'(n_out), 1);

    // Randomised run on the wide build.
    words = 0; got = 0; bound = 0; racc = 0; rstall = 0; rprev = 0;
    while (got < 10000 && bound < 60000) begin
      r_in_valid  = (words < 10000) && ($urandom % 4 != 0);
      r_in_data   = 16'($urandom);
      r_in_mode   = 1'($urandom);
      r_out_ready = ($urandom % 4 != 0);
      #1;
      if (rstall) chk("rand_hold", 32'(r_out_data), rprev);
      if (r_out_valid && r_out_ready) begin
        re = (rq.size() != 0) ? rq.pop_front() : 32'hFFFF_FFFF;
        chk("rand_data", 32'(r_out_data), re);
        got++;
      end
      if (r_in_valid && r_in_ready) begin
        re = dig({16'd0, r_in_data}, 32, 5);
        if (r_in_mode) begin racc ^= re; rq.push_back(racc); end
        else rq.push_back(re);
        words++;
      end
      rstall = r_out_valid && !r_out_ready;
      rprev  = 32'(r_out_data);
      @(posedge clk);
      #1;
      bound++;
    end
    r_in_valid = 0;
    if (got < 10000) chk("rand_timeout", 32'(got), 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
